// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg
// Shared definitions for the hart's stage sequencer.
//   seq_state_t        : top-level sequencer state (run / halted / fault)
//   DEFAULT_NUM_STAGES : default stage-loop length; the hart's stage enum
//                        is expected to align with this value.
package stage_sequencer_pkg;

    localparam int DEFAULT_NUM_STAGES = 5;

    typedef enum logic [1:0] {
        SEQ_RUN    = 2'd0,
        SEQ_HALTED = 2'd1,
        SEQ_FAULT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/stage_skip_encoder.sv
// stage_skip_encoder
// Combinational, wrap-free priority search for the next stage to run.
// Ports:
//   stage_skip_i : per-stage "not needed" flags
//   cur_idx_i    : index of the stage that is completing
//   next_idx_o   : lowest index above cur_idx_i whose skip flag is low
//   none_left_o  : high when every stage above cur_idx_i is skipped
//                  (the completing stage is then the last of the instruction)
module stage_skip_encoder #(
    parameter int NUM_STAGES = 5,
    parameter int IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic [NUM_STAGES-1:0] stage_skip_i,
    input  logic [IDX_W-1:0]      cur_idx_i,
    output logic [IDX_W-1:0]      next_idx_o,
    output logic                  none_left_o
);

    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_idx_o  = '0;
        none_left_o = 1'b1;
        // Scan from the top down so the lowest qualifying index is the last
        // one written. Indices at or below the current one never qualify,
        // so the search cannot wrap back to stage 0.
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (j > int'(cur_idx_i) && !stage_skip_i[j]) begin
                next_idx_o  = IDX_W'(j);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer
// Steps the hart's N-stage instruction loop on per-stage completion
// handshakes, with debug halt / single-step, a per-stage watchdog and
// cycle / retire counters.
// Optional feature: define STAGE_SKIP_EN to let stage_skip bypass stages
// (zero-cycle skip via stage_skip_encoder); undefined, stage_skip is ignored
// and every stage advances to the next one.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   stage_complete   : per-stage done flags (only the active stage's bit used)
//   stage_skip       : per-stage skip flags (bit 0 ignored)
//   halt_req         : halt at the next instruction boundary (level)
//   step_req         : while halted, run exactly one instruction
//   stage_active     : one-hot active stage, zero when halted or faulted
//   stage_index      : index of the active stage
//   retire           : combinational pulse when the last stage completes
//   halted           : sequencer is halted
//   timeout_fault    : sticky watchdog fault
//   cycle_count      : cycles spent running since reset
//   retired_count    : retire pulses since reset
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = DEFAULT_NUM_STAGES,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int COUNTER_WIDTH  = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_STAGES-1:0]         stage_complete,
    input  logic [NUM_STAGES-1:0]         stage_skip,
    input  logic                          halt_req,
    input  logic                          step_req,
    output logic [NUM_STAGES-1:0]         stage_active,
    output logic [$clog2(NUM_STAGES)-1:0] stage_index,
    output logic                          retire,
    output logic                          halted,
    output logic                          timeout_fault,
    output logic [COUNTER_WIDTH-1:0]      cycle_count,
    output logic [COUNTER_WIDTH-1:0]      retired_count
);

    localparam int IDX_W    = $clog2(NUM_STAGES);
    localparam int DWELL_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    seq_state_t               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     step_q, step_d;
    logic [DWELL_W-1:0]       dwell_q, dwell_d;
    logic [COUNTER_WIDTH-1:0] cycle_q, cycle_d;
    logic [COUNTER_WIDTH-1:0] retired_q, retired_d;

    logic [IDX_W-1:0]         adv_idx;
    logic                     is_last;
    logic                     done;

`ifdef STAGE_SKIP_EN
    logic none_left;

    stage_skip_encoder #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (IDX_W)
    ) u_skip_enc (
        .stage_skip_i (stage_skip),
        .cur_idx_i    (idx_q),
        .next_idx_o   (adv_idx),
        .none_left_o  (none_left)
    );

    // The final stage always has nothing above it, so "none left" covers
    // both the natural end of the loop and a skipped tail.
    assign is_last = none_left;
`else
    logic unused_skip;

    assign unused_skip = ^stage_skip;
    assign adv_idx     = idx_q + IDX_W'(1);
    assign is_last     = (idx_q == IDX_W'(NUM_STAGES - 1));
`endif

    assign done = (state_q == SEQ_RUN) && stage_complete[idx_q];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;
        // A reset in the completing cycle aborts the instruction, so the PC
        // logic must not see a retire.
        retire    = done && is_last && !reset;

        unique case (state_q)
            SEQ_RUN: begin
                cycle_d = cycle_q + COUNTER_WIDTH'(1);
                if (done) begin
                    dwell_d = '0;
                    if (is_last) begin
                        retired_d = retired_q + COUNTER_WIDTH'(1);
                        idx_d     = '0;
                        // halt_req only matters at the instruction boundary;
                        // a step always lands back in halted.
                        if (halt_req || step_q) begin
                            state_d = SEQ_HALTED;
                            step_d  = 1'b0;
                        end
                    end else begin
                        idx_d = adv_idx;
                    end
                end else if ((TIMEOUT_CYCLES > 0) && (dwell_q == DWELL_W'(TMO_LAST))) begin
                    // Completion in the final allowed cycle is handled above,
                    // so a coincident timeout never fires.
                    state_d = SEQ_FAULT;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end

            SEQ_HALTED: begin
                idx_d   = '0;
                dwell_d = '0;
                if (step_req) begin
                    state_d = SEQ_RUN;
                    step_d  = 1'b1;
                end else if (!halt_req) begin
                    state_d = SEQ_RUN;
                end
            end

            SEQ_FAULT: begin
                // Everything holds until reset.
            end

            default: begin
                state_d = SEQ_RUN;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clock) begin
        // NOTE: reset is sampled on the clock edge; there is no async path.
        if (reset) begin
            state_q   <= SEQ_RUN;
            idx_q     <= '0;
            step_q    <= 1'b0;
            dwell_q   <= '0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            dwell_q   <= dwell_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_active[i] = (state_q == SEQ_RUN) && (idx_q == IDX_W'(i));
        end
    end

    assign stage_index   = idx_q;
    assign halted        = (state_q == SEQ_HALTED);
    assign timeout_fault = (state_q == SEQ_FAULT);
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer
// Self-checking bench for stage_sequencer (NUM_STAGES=5, TIMEOUT_CYCLES=8).
// A behavioural model tracks the instruction loop as "current stage number
// plus cycles spent in it" and derives the expected outputs from the stage
// rules; scenario tasks compare the DUT against that model and against
// constants worked out from the stage rules.
module tb_stage_sequencer;

    localparam int N   = 5;
    localparam int TMO = 8;
    localparam int CW  = 32;
`ifdef STAGE_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  stage_complete;
    logic [N-1:0]  stage_skip;
    logic          halt_req;
    logic          step_req;
    logic [N-1:0]  stage_active;
    logic [$clog2(N)-1:0] stage_index;
    logic          retire;
    logic          halted;
    logic          timeout_fault;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] retired_count;

    always #5 clock = ~clock;

    stage_sequencer #(
        .NUM_STAGES     (N),
        .TIMEOUT_CYCLES (TMO),
        .COUNTER_WIDTH  (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stage_complete (stage_complete),
        .stage_skip     (stage_skip),
        .halt_req       (halt_req),
        .step_req       (step_req),
        .stage_active   (stage_active),
        .stage_index    (stage_index),
        .retire         (retire),
        .halted         (halted),
        .timeout_fault  (timeout_fault),
        .cycle_count    (cycle_count),
        .retired_count  (retired_count)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    typedef enum {M_RUN, M_HALTED, M_FAULT} mode_e;
    mode_e         m_mode;
    int            m_stage;
    int            m_dwell;
    bit            m_stepping;
    logic [CW-1:0] m_cycles;
    logic [CW-1:0] m_retired;

    // Sampled DUT outputs and model expectations for the current cycle.
    logic [N-1:0]  obs_active,  exp_active;
    int            obs_index,   exp_index;
    logic          obs_retire,  exp_retire;
    logic          obs_halted,  exp_halted;
    logic          obs_fault,   exp_fault;
    logic [CW-1:0] obs_cycles,  exp_cycles;
    logic [CW-1:0] obs_retired, exp_retired;
    bit            exp_running;

    // Next stage to run after stage i completes; N means the instruction ends.
    function automatic int next_stage(int i, logic [N-1:0] skip);
        if (!SKIP_EN) return i + 1;
        for (int j = i + 1; j < N; j++) begin
            if (!skip[j]) return j;
        end
        return N;
    endfunction

    task automatic model_reset();
        m_mode     = M_RUN;
        m_stage    = 0;
        m_dwell    = 0;
        m_stepping = 1'b0;
        m_cycles   = '0;
        m_retired  = '0;
    endtask

    // Drive one cycle of inputs, sample the DUT mid-cycle, compute the
    // model's expectations for that cycle, then advance the model across
    // the clock edge.
    task automatic run_cycle(input logic [N-1:0] cmp, input logic [N-1:0] skp,
                             input logic hlt, input logic stp, input logic rst);
        int nxt;
        stage_complete = cmp;
        stage_skip     = skp;
        halt_req       = hlt;
        step_req       = stp;
        reset          = rst;
        #2;
        obs_active  = stage_active;
        obs_index   = int'(stage_index);
        obs_retire  = retire;
        obs_halted  = halted;
        obs_fault   = timeout_fault;
        obs_cycles  = cycle_count;
        obs_retired = retired_count;

        exp_running = (m_mode == M_RUN);
        exp_active  = '0;
        if (exp_running) exp_active[m_stage] = 1'b1;
        exp_index   = m_stage;
        exp_halted  = (m_mode == M_HALTED);
        exp_fault   = (m_mode == M_FAULT);
        exp_cycles  = m_cycles;
        exp_retired = m_retired;
        nxt         = next_stage(m_stage, skp);
        exp_retire  = exp_running && cmp[m_stage] && (nxt == N) && !rst;

        if (rst) begin
            model_reset();
        end else begin
            case (m_mode)
                M_RUN: begin
                    m_cycles = m_cycles + 1;
                    if (cmp[m_stage]) begin
                        m_dwell = 0;
                        if (nxt == N) begin
                            m_retired = m_retired + 1;
                            m_stage   = 0;
                            if (hlt || m_stepping) begin
                                m_mode     = M_HALTED;
                                m_stepping = 1'b0;
                            end
                        end else begin
                            m_stage = nxt;
                        end
                    end else if (m_dwell == TMO - 1) begin
                        m_mode = M_FAULT;
                    end else begin
                        m_dwell++;
                    end
                end
                M_HALTED: begin
                    if (stp) begin
                        m_mode     = M_RUN;
                        m_stage    = 0;
                        m_dwell    = 0;
                        m_stepping = 1'b1;
                    end else if (!hlt) begin
                        m_mode  = M_RUN;
                        m_stage = 0;
                        m_dwell = 0;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        run_cycle('0, '0, 1'b0, 1'b0, 1'b1);
        run_cycle('0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_active !== 5'b00001) begin errors++; $display("FAIL reset_active got %b want 00001", obs_active); end
        checks++; if (obs_index !== 0) begin errors++; $display("FAIL reset_index got %0d want 0", obs_index); end
        checks++; if (obs_retire !== 1'b0) begin errors++; $display("FAIL reset_retire got %b want 0", obs_retire); end
        checks++; if (obs_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", obs_halted); end
        checks++; if (obs_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", obs_fault); end
        checks++; if (obs_cycles !== 0) begin errors++; $display("FAIL reset_cycles got %0d want 0", obs_cycles); end
        checks++; if (obs_retired !== 0) begin errors++; $display("FAIL reset_retired got %0d want 0", obs_retired); end
    endtask

    task automatic test_all_stages();
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_retire !== ((k % 5) == 0)) begin
                errors++; $display("FAIL all_retire cycle %0d got %b want %b", k, obs_retire, (k % 5) == 0);
            end
            checks++;
            if (obs_index !== (k - 1) % 5) begin
                errors++; $display("FAIL all_index cycle %0d got %0d want %0d", k, obs_index, (k - 1) % 5);
            end
        end
        run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_retired !== 4) begin errors++; $display("FAIL all_retired got %0d want 4", obs_retired); end
        checks++; if (obs_cycles !== 20) begin errors++; $display("FAIL all_cycles got %0d want 20", obs_cycles); end
    endtask

    task automatic test_skip();
        int per;
        int want_idx;
        apply_reset();
        per = SKIP_EN ? 3 : 5;
        for (int k = 1; k <= 15; k++) begin
            run_cycle('1, 5'b01010, 1'b0, 1'b0, 1'b0);
            want_idx = SKIP_EN ? 2 * ((k - 1) % 3) : (k - 1) % 5;
            checks++;
            if (obs_retire !== ((k % per) == 0)) begin
                errors++; $display("FAIL skip_retire cycle %0d got %b want %b", k, obs_retire, (k % per) == 0);
            end
            checks++;
            if (obs_index !== want_idx) begin
                errors++; $display("FAIL skip_index cycle %0d got %0d want %0d", k, obs_index, want_idx);
            end
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
        run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= TMO; c++) begin
            run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_fault !== 1'b0 || obs_active !== 5'b00100) begin
                errors++; $display("FAIL wd_wait cycle %0d fault %b active %b want 0 00100", c, obs_fault, obs_active);
            end
        end
        for (int c = 0; c < 10; c++) begin
            run_cycle(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            checks++;
            if (obs_fault !== 1'b1 || obs_active !== '0 || obs_retire !== 1'b0) begin
                errors++; $display("FAIL wd_fault cycle %0d fault %b active %b retire %b want 1 00000 0",
                                   c, obs_fault, obs_active, obs_retire);
            end
            checks++;
            if (obs_cycles !== 10 || obs_retired !== 0) begin
                errors++; $display("FAIL wd_frozen cycles %0d retired %0d want 10 0", obs_cycles, obs_retired);
            end
        end
    endtask

    task automatic test_boundary();
        apply_reset();
        run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
        run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < TMO; c++) run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
        run_cycle(5'b00100, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_fault !== 1'b0) begin errors++; $display("FAIL race_fault_pre got %b want 0", obs_fault); end
        run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_fault !== 1'b0) begin errors++; $display("FAIL race_fault got %b want 0", obs_fault); end
        checks++; if (obs_active !== 5'b01000) begin errors++; $display("FAIL race_active got %b want 01000", obs_active); end
    endtask

    task automatic test_halt_step();
        int n_ret;
        apply_reset();
        run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
        run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 3; k <= 5; k++) begin
            run_cycle('1, '0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_retire !== (k == 5)) begin errors++; $display("FAIL halt_retire cycle %0d got %b want %b", k, obs_retire, k == 5); end
        end
        for (int k = 0; k < 3; k++) begin
            run_cycle('1, '0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_halted !== 1'b1 || obs_active !== '0) begin
                errors++; $display("FAIL halt_hold %0d halted %b active %b want 1 00000", k, obs_halted, obs_active);
            end
        end
        // One-cycle step with halt_req still high: step wins.
        run_cycle('0, '0, 1'b1, 1'b1, 1'b0);
        n_ret = 0;
        for (int k = 0; k < 10; k++) begin
            run_cycle('1, '0, 1'b1, 1'b0, 1'b0);
            if (k == 0) begin
                checks++;
                if (obs_active !== 5'b00001) begin errors++; $display("FAIL step_start got %b want 00001", obs_active); end
            end
            n_ret += int'(obs_retire);
        end
        checks++; if (n_ret !== 1) begin errors++; $display("FAIL step_retires got %0d want 1", n_ret); end
        checks++; if (obs_halted !== 1'b1) begin errors++; $display("FAIL step_rehalt got %b want 1", obs_halted); end
        run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
        run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_active !== 5'b00001 || obs_index !== 0 || obs_halted !== 1'b0) begin
            errors++; $display("FAIL resume active %b index %0d halted %b want 00001 0 0", obs_active, obs_index, obs_halted);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 8; k++) run_cycle('1, '0, 1'b0, 1'b0, 1'b0);
        run_cycle('1, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (obs_index !== 3) begin errors++; $display("FAIL rstmid_pre_index got %0d want 3", obs_index); end
        checks++; if (obs_retire !== 1'b0) begin errors++; $display("FAIL rstmid_retire got %b want 0", obs_retire); end
        run_cycle('0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_index !== 0 || obs_active !== 5'b00001 || obs_cycles !== 0 || obs_retired !== 0 || obs_retire !== 1'b0) begin
            errors++; $display("FAIL rstmid_post index %0d active %b cycles %0d retired %0d retire %b want 0 00001 0 0 0",
                               obs_index, obs_active, obs_cycles, obs_retired, obs_retire);
        end
    endtask

    task automatic test_random();
        logic hlt;
        logic [N-1:0] cmp;
        apply_reset();
        hlt = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) hlt = ~hlt;
            cmp = ~(N'($urandom) & N'($urandom));
            run_cycle(cmp, N'($urandom), hlt, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
            checks++;
            if (obs_active !== exp_active || obs_retire !== exp_retire) begin
                errors++; $display("FAIL rand_out cycle %0d active %b retire %b want %b %b",
                                   k, obs_active, obs_retire, exp_active, exp_retire);
            end
            checks++;
            if (obs_halted !== exp_halted || obs_fault !== exp_fault) begin
                errors++; $display("FAIL rand_state cycle %0d halted %b fault %b want %b %b",
                                   k, obs_halted, obs_fault, exp_halted, exp_fault);
            end
            checks++;
            if (obs_cycles !== exp_cycles || obs_retired !== exp_retired) begin
                errors++; $display("FAIL rand_count cycle %0d cycles %0d retired %0d want %0d %0d",
                                   k, obs_cycles, obs_retired, exp_cycles, exp_retired);
            end
            if (exp_running) begin
                checks++;
                if (obs_index !== exp_index) begin
                    errors++; $display("FAIL rand_index cycle %0d got %0d want %0d", k, obs_index, exp_index);
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        stage_complete = '0;
        stage_skip     = '0;
        halt_req       = 1'b0;
        step_req       = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        test_reset();
        test_all_stages();
        test_skip();
        test_watchdog();
        test_boundary();
        test_halt_step();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multi-cycle control sequencer for the hart. It steps an N-stage instruction loop on per-stage completion handshakes and optionally skips stages the current instruction does not need. It also provides debug halt and single-step, a per-stage watchdog timeout, and cycle/retire counters. It replaces the hard-wired five-stage progression in the hart and sits between the stage modules and the PC-update logic.

## Interface
- NUM_STAGES, 5: number of stages in the loop; min 2.
- TIMEOUT_CYCLES, 0: maximum cycles a stage may stay active without completing. 0 disables the watchdog.
- COUNTER_WIDTH, 32: width of the performance counters.
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- stage_complete  in  NUM_STAGES  bit i high = stage i finished this cycle; only the active stage's bit is used.
- stage_skip  in  NUM_STAGES  bit i high = stage i is unneeded for the current instruction; bit 0 is ignored.
- halt_req  in  1  request halt at the next instruction boundary (level).
- step_req  in  1  while halted, execute exactly one instruction (sampled each cycle).
- stage_active  out  NUM_STAGES  one-hot active stage; all zero when halted or faulted.
- stage_index  out  $clog2(NUM_STAGES)  index of the active stage.
- retire  out  1  one-cycle pulse: last stage is active and completes this cycle.
- halted  out  1  sequencer is in the halted state.
- timeout_fault  out  1  sticky watchdog fault.
- cycle_count  out  COUNTER_WIDTH  non-halted, non-faulted cycles since reset.
- retired_count  out  COUNTER_WIDTH  retire pulses since reset.

## Operation
- States: SEQ_RUN, SEQ_HALTED, SEQ_FAULT. Reset enters SEQ_RUN with stage 0 active.
- Reset values:
  - stage_active = 1, stage_index = 0.
  - retire = 0, halted = 0, timeout_fault = 0.
  - Both counters = 0.
  - Internal dwell counter = 0.
- Advancing within SEQ_RUN:
  - Stage i with stage_complete[i] high, i < NUM_STAGES-1, advances to the next stage per the Configuration rule.
  - The last stage completing asserts retire.
  - After a retire, the next state is SEQ_HALTED if halt_req is high or a single-step is in progress. Otherwise it is stage 0.
- Halt and step:
  - SEQ_HALTED with step_req high: go to SEQ_RUN stage 0 and set the step flag. At that instruction's retire, return to SEQ_HALTED regardless of halt_req.
  - SEQ_HALTED with step_req low and halt_req low: resume at stage 0.
  - If step_req and halt_req are both high, step_req wins.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The dwell counter clears on every stage change and increments otherwise.
  - If the dwell counter equals TIMEOUT_CYCLES-1 and the stage does not complete that cycle, enter SEQ_FAULT next cycle.
  - If completion and timeout coincide, completion wins.
  - SEQ_FAULT holds, with counters frozen, until reset.
- Counters:
  - cycle_count increments every cycle in SEQ_RUN.
  - retired_count increments on retire.
  - Both wrap modulo 2^COUNTER_WIDTH.
- Reset mid-instruction aborts the instruction: no retire, and all state returns to reset values.

## Timing
- stage_active, stage_index and halted are registered: they change on the clock edge after the completing cycle.
- retire is combinational, valid in the same cycle as the last stage's completion, so the PC can update on that edge.
- Minimum instruction latency: one cycle per non-skipped stage. With all stages completing immediately and no skips, that is NUM_STAGES cycles.
- halt_req is sampled only in the retire cycle. Latency from that cycle to halted=1 is one cycle.
- Resume or step: stage 0 is active one cycle after the deciding sample.

## Configuration
- STAGE_SKIP_EN defined:
  - From stage i, advance to the lowest j > i with stage_skip[j] low, sampled in the completing cycle.
  - If every stage above i is skipped, stage i's completion is treated as the retire.
  - A skipped stage costs zero cycles.
- STAGE_SKIP_EN undefined: stage_skip is ignored, and each stage always advances to i+1.

## Structure
- Shared package holds:
  - The seq_state_t enum (SEQ_RUN, SEQ_HALTED, SEQ_FAULT).
  - The default stage-count constant, which the hart's stage enum will align to.
- Sub-module stage_skip_encoder: a combinational wrap-free priority search over stage_skip above the current index. It returns the next index and an "none left" flag. It is instantiated only under STAGE_SKIP_EN.

## Test plan
- All-stages run: NUM_STAGES=5, stage_complete all high for 20 cycles.
  - retire pulses at cycles 5, 10, 15, 20.
  - retired_count = 4, cycle_count = 20.
- Skip path: STAGE_SKIP_EN with stage_skip = 5'b01010.
  - Sequence is 0, 2, 4, and retire fires every 3 cycles.
  - With the macro undefined, the same stimulus retires every 5 cycles.
- Watchdog: TIMEOUT_CYCLES=8, stage_complete[2] held low.
  - timeout_fault rises exactly 8 cycles after stage 2 is entered, with stage_active = 0.
  - Further stimulus changes nothing until reset.
- Boundary race: TIMEOUT_CYCLES=8, stage_complete[2] first asserted in the 8th cycle → normal advance, no fault.
- Halt and step:
  - Assert halt_req mid-instruction → halted=1 the cycle after that instruction's retire, with stage_active = 0.
  - A 1-cycle step_req → exactly one retire, then halted again.
  - Dropping halt_req → resume at stage 0.
- Reset mid-operation: assert reset while stage 3 is active → next cycle stage_index = 0, counters = 0, no retire pulse.
